ddr3_init_sequencer: RTL and testbench

- Parametrised DDR3 power-up and reset initialization sequencer, per JEDEC DDR3 sequence.
- Drives RESET#, CKE, chip selects and the command/address bus for the 4:1 controller until the DRAM is usable, then hands the bus over via o_init_done.
- Generalised in three ways: rank count, programmable mode-register values, and a simulation-shortening mode.
- Supports re-initialization on request.

---
 rtl/ddr3_init_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ddr3_init_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_init_sequencer.sv
// Purpose : JEDEC DDR3 power-up/reset initialization sequencer for a 4:1 controller.
// Latency : all outputs registered; every state holding delay D occupies exactly D cycles.
// Backpres: none; owns the DRAM bus until o_init_done, i_reinit honoured only in DONE.
module ddr3_init_sequencer #(
    parameter int          CLK_PERIOD_PS = 5000,
    parameter int          RANKS         = 1,
    parameter int          ROW_BITS      = 14,
    parameter int          BA_BITS       = 3,
    parameter int          TIMER_BITS    = 20,
    parameter int          T_RESET_NS    = 200000,
    parameter int          T_CKE_NS      = 500000,
    parameter int          T_XPR_NS      = 170,
    parameter int          T_MOD_CYC     = 3,
    parameter int          T_MRD_CYC     = 1,
    parameter int          T_ZQINIT_CYC  = 128,
    parameter logic [15:0] MR0           = 16'h0D70,
    parameter logic [15:0] MR1           = 16'h0004,
    parameter logic [15:0] MR2           = 16'h0018,
    parameter logic [15:0] MR3           = 16'h0000,
    parameter int          SIM_SHORT     = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_reinit,
    output logic                o_reset_n,
    output logic                o_cke,
    output logic [RANKS-1:0]    o_cs_n,
    output logic                o_ras_n,
    output logic                o_cas_n,
    output logic                o_we_n,
    output logic [BA_BITS-1:0]  o_ba,
    output logic [ROW_BITS-1:0] o_addr,
    output logic                o_odt,
    output logic                o_init_done,
    output logic [3:0]          o_state
);

    // ---------------------------------------------------------------
    // Elaboration-time delay conversion (ceil of ns -> cycles, min 1)
    // ---------------------------------------------------------------
    function automatic longint ns_to_cyc(input longint ns);
        longint c;
        c = (ns * 64'sd1000 + longint'(CLK_PERIOD_PS) - 64'sd1) / longint'(CLK_PERIOD_PS);
        if (c < 64'sd1) c = 64'sd1;
        return c;
    endfunction

    function automatic longint at_least_1(input longint v);
        return (v < 64'sd1) ? 64'sd1 : v;
    endfunction

    localparam longint D_RESET = (SIM_SHORT != 0) ? 64'sd16 : ns_to_cyc(longint'(T_RESET_NS));
    localparam longint D_CKE   = (SIM_SHORT != 0) ? 64'sd16 : ns_to_cyc(longint'(T_CKE_NS));
    localparam longint D_XPR   = ns_to_cyc(longint'(T_XPR_NS));
    localparam longint D_MOD   = at_least_1(longint'(T_MOD_CYC));
    localparam longint D_MRD   = at_least_1(longint'(T_MRD_CYC));
    localparam longint D_ZQ    = at_least_1(longint'(T_ZQINIT_CYC));
    localparam longint T_MAX   = (64'sd1 <<< TIMER_BITS) - 64'sd1;

    // Reject configurations the timer or buses cannot represent.
    generate
        if (D_RESET > T_MAX || D_CKE > T_MAX || D_XPR > T_MAX ||
            D_MOD > T_MAX || D_MRD > T_MAX || D_ZQ > T_MAX) begin : g_err_timer
            $error("ddr3_init_sequencer: a delay exceeds the TIMER_BITS range");
        end
        if (RANKS < 1 || RANKS > 4) begin : g_err_ranks
            $error("ddr3_init_sequencer: RANKS must be 1..4");
        end
        if (ROW_BITS < 11 || ROW_BITS > 64) begin : g_err_row
            $error("ddr3_init_sequencer: ROW_BITS must be 11..64 (ZQCL needs A10)");
        end
        if (BA_BITS < 2) begin : g_err_ba
            $error("ddr3_init_sequencer: BA_BITS must be at least 2");
        end
    endgenerate

    // Timer reload values are delay-1 so a state lasts exactly its delay.
    localparam logic [TIMER_BITS-1:0] L_RESET = TIMER_BITS'(D_RESET - 64'sd1);
    localparam logic [TIMER_BITS-1:0] L_CKE   = TIMER_BITS'(D_CKE - 64'sd1);
    localparam logic [TIMER_BITS-1:0] L_XPR   = TIMER_BITS'(D_XPR - 64'sd1);
    localparam logic [TIMER_BITS-1:0] L_MOD   = TIMER_BITS'(D_MOD - 64'sd1);
    localparam logic [TIMER_BITS-1:0] L_MRD   = TIMER_BITS'(D_MRD - 64'sd1);
    localparam logic [TIMER_BITS-1:0] L_ZQ    = TIMER_BITS'(D_ZQ - 64'sd1);

    localparam logic [1:0] LAST_RANK = 2'(RANKS - 1);

    // Mode-register payloads zero-extended or truncated to the address width.
    function automatic logic [ROW_BITS-1:0] fit_addr(input logic [15:0] v);
        logic [63:0] t;
        t = {48'd0, v};
        return t[ROW_BITS-1:0];
    endfunction

    localparam logic [ROW_BITS-1:0] A_MR0 = fit_addr(MR0);
    localparam logic [ROW_BITS-1:0] A_MR1 = fit_addr(MR1);
    localparam logic [ROW_BITS-1:0] A_MR2 = fit_addr(MR2);
    localparam logic [ROW_BITS-1:0] A_MR3 = fit_addr(MR3);
    localparam logic [ROW_BITS-1:0] A_ZQ  = fit_addr(16'h0400);

    typedef enum logic [3:0] {
        S_RESET_HOLD = 4'd0,
        S_CKE_WAIT   = 4'd1,
        S_TXPR       = 4'd2,
        S_MRS2       = 4'd3,
        S_MRS3       = 4'd4,
        S_MRS1       = 4'd5,
        S_MRS0       = 4'd6,
        S_ZQCL       = 4'd7,
        S_DONE       = 4'd8
    } state_t;

    function automatic state_t succ(input state_t s);
        case (s)
            S_RESET_HOLD: return S_CKE_WAIT;
            S_CKE_WAIT:   return S_TXPR;
            S_TXPR:       return S_MRS2;
            S_MRS2:       return S_MRS3;
            S_MRS3:       return S_MRS1;
            S_MRS1:       return S_MRS0;
            S_MRS0:       return S_ZQCL;
            default:      return S_DONE;
        endcase
    endfunction

    function automatic logic [TIMER_BITS-1:0] load_of(input state_t s);
        case (s)
            S_RESET_HOLD: return L_RESET;
            S_CKE_WAIT:   return L_CKE;
            S_TXPR:       return L_XPR;
            S_MRS2,
            S_MRS3,
            S_MRS1:       return L_MRD;
            S_MRS0:       return L_MOD;
            S_ZQCL:       return L_ZQ;
            default:      return '0;
        endcase
    endfunction

    // States that repeat their command-plus-wait once per rank.
    function automatic logic is_ranked(input state_t s);
        return (s == S_MRS2) || (s == S_MRS3) || (s == S_MRS1) ||
               (s == S_MRS0) || (s == S_ZQCL);
    endfunction

    state_t                  r_state;
    logic [TIMER_BITS-1:0]   r_timer;
    logic [1:0]              r_rank;

    state_t                  w_nxt_state;
    logic [TIMER_BITS-1:0]   w_nxt_timer;
    logic [1:0]              w_nxt_rank;
    logic                    w_issue;

    logic                    r_reset_n, r_cke, r_ras_n, r_cas_n, r_we_n, r_init_done;
    logic [RANKS-1:0]        r_cs_n;
    logic [BA_BITS-1:0]      r_ba;
    logic [ROW_BITS-1:0]     r_addr;

    logic                    w_reset_n, w_cke, w_ras_n, w_cas_n, w_we_n, w_init_done;
    logic [RANKS-1:0]        w_cs_n;
    logic [BA_BITS-1:0]      w_ba;
    logic [ROW_BITS-1:0]     w_addr;

    // State, delay timer and rank index registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_RESET_HOLD;
            r_timer <= L_RESET;
            r_rank  <= 2'd0;
        end else begin
            r_state <= w_nxt_state;
            r_timer <= w_nxt_timer;
            r_rank  <= w_nxt_rank;
        end
    end

    // Next state: count down, then step rank or advance; w_issue marks a command cycle.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_timer = r_timer;
        w_nxt_rank  = r_rank;
        w_issue     = 1'b0;
        if (r_state == S_DONE) begin
            if (i_reinit) begin
                w_nxt_state = S_RESET_HOLD;
                w_nxt_timer = L_RESET;
                w_nxt_rank  = 2'd0;
            end
        end else if (r_timer != '0) begin
            w_nxt_timer = r_timer - TIMER_BITS'(1);
        end else if (is_ranked(r_state) && (r_rank != LAST_RANK)) begin
            w_nxt_rank  = r_rank + 2'd1;
            w_nxt_timer = load_of(r_state);
            w_issue     = 1'b1;
        end else begin
            w_nxt_state = succ(r_state);
            w_nxt_timer = load_of(succ(r_state));
            w_nxt_rank  = 2'd0;
            w_issue     = is_ranked(succ(r_state));
        end
    end

    // Output decode from the upcoming state so every pin comes straight from a flop.
    always_comb begin
        w_reset_n   = 1'b1;
        w_cke       = 1'b1;
        w_cs_n      = '1;
        w_ras_n     = 1'b1;
        w_cas_n     = 1'b1;
        w_we_n      = 1'b1;
        w_ba        = '0;
        w_addr      = '0;
        w_init_done = (w_nxt_state == S_DONE);
        case (w_nxt_state)
            S_RESET_HOLD: begin
                w_reset_n = 1'b0;
                w_cke     = 1'b0;
            end
            S_CKE_WAIT: w_cke = 1'b0;
            default: ;
        endcase
        if (w_issue) begin
            for (int i = 0; i < RANKS; i++) begin
                if (w_nxt_rank == 2'(i)) w_cs_n[i] = 1'b0;
            end
            if (w_nxt_state == S_ZQCL) begin
                w_we_n = 1'b0;
                w_addr = A_ZQ;
            end else begin
                w_ras_n = 1'b0;
                w_cas_n = 1'b0;
                w_we_n  = 1'b0;
                case (w_nxt_state)
                    S_MRS2:  begin w_ba = BA_BITS'(2); w_addr = A_MR2; end
                    S_MRS3:  begin w_ba = BA_BITS'(3); w_addr = A_MR3; end
                    S_MRS1:  begin w_ba = BA_BITS'(1); w_addr = A_MR1; end
                    default: begin w_ba = BA_BITS'(0); w_addr = A_MR0; end
                endcase
            end
        end
    end

    // Output registers; reset forces an idle bus with RESET# and CKE low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_reset_n   <= 1'b0;
            r_cke       <= 1'b0;
            r_cs_n      <= '1;
            r_ras_n     <= 1'b1;
            r_cas_n     <= 1'b1;
            r_we_n      <= 1'b1;
            r_ba        <= '0;
            r_addr      <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_reset_n   <= w_reset_n;
            r_cke       <= w_cke;
            r_cs_n      <= w_cs_n;
            r_ras_n     <= w_ras_n;
            r_cas_n     <= w_cas_n;
            r_we_n      <= w_we_n;
            r_ba        <= w_ba;
            r_addr      <= w_addr;
            r_init_done <= w_init_done;
        end
    end

    assign o_reset_n   = r_reset_n;
    assign o_cke       = r_cke;
    assign o_cs_n      = r_cs_n;
    assign o_ras_n     = r_ras_n;
    assign o_cas_n     = r_cas_n;
    assign o_we_n      = r_we_n;
    assign o_ba        = r_ba;
    assign o_addr      = r_addr;
    assign o_odt       = 1'b0;
    assign o_init_done = r_init_done;
    assign o_state     = r_state;

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Purpose : checks sequence timing, command contents, reset abort and reinit of ddr3_init_sequencer.
// Latency : counts edges from reset release / reinit sample edge; outputs sampled on the falling edge.
// Backpres: none; the bench only drives reset and reinit.
module tb_ddr3_init_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1 = 1'b1, rstb = 1'b1, reinit1 = 1'b0, reinit0 = 1'b0, restart1 = 1'b0;

    logic        rn1, cke1, ras1, cas1, we1, odt1, done1;
    logic [0:0]  cs1;
    logic [2:0]  ba1;
    logic [13:0] addr1;
    logic [3:0]  st1;
    logic        rn2, cke2, ras2, cas2, we2, odt2, done2;
    logic [1:0]  cs2;
    logic [2:0]  ba2;
    logic [13:0] addr2;
    logic [3:0]  st2;
    logic        rn3, cke3, ras3, cas3, we3, odt3, done3;
    logic [0:0]  cs3;
    logic [2:0]  ba3;
    logic [13:0] addr3;
    logic [3:0]  st3;
    logic        rn4, cke4, ras4, cas4, we4, odt4, done4;
    logic [0:0]  cs4;
    logic [2:0]  ba4;
    logic [13:0] addr4;
    logic [3:0]  st4;

    ddr3_init_sequencer #(.RANKS(1), .SIM_SHORT(1)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_reinit(reinit1), .o_reset_n(rn1), .o_cke(cke1),
        .o_cs_n(cs1), .o_ras_n(ras1), .o_cas_n(cas1), .o_we_n(we1), .o_ba(ba1),
        .o_addr(addr1), .o_odt(odt1), .o_init_done(done1), .o_state(st1));
    ddr3_init_sequencer #(.RANKS(2), .SIM_SHORT(1)) dut2 (
        .i_clk(clk), .i_rst(rstb), .i_reinit(reinit0), .o_reset_n(rn2), .o_cke(cke2),
        .o_cs_n(cs2), .o_ras_n(ras2), .o_cas_n(cas2), .o_we_n(we2), .o_ba(ba2),
        .o_addr(addr2), .o_odt(odt2), .o_init_done(done2), .o_state(st2));
    // Real (unshortened) delays with a slow clock: 4000 / 10000 / ceil(3.4)=4 cycles.
    ddr3_init_sequencer #(.CLK_PERIOD_PS(50000), .SIM_SHORT(0)) dut3 (
        .i_clk(clk), .i_rst(rstb), .i_reinit(reinit0), .o_reset_n(rn3), .o_cke(cke3),
        .o_cs_n(cs3), .o_ras_n(ras3), .o_cas_n(cas3), .o_we_n(we3), .o_ba(ba3),
        .o_addr(addr3), .o_odt(odt3), .o_init_done(done3), .o_state(st3));
    // Rounding corners at 5000 ps: 1001 ns -> 201, 0 ns -> 1 (minimum), 5 ns -> 1.
    ddr3_init_sequencer #(.T_RESET_NS(1001), .T_CKE_NS(0), .T_XPR_NS(5)) dut4 (
        .i_clk(clk), .i_rst(rstb), .i_reinit(reinit0), .o_reset_n(rn4), .o_cke(cke4),
        .o_cs_n(cs4), .o_ras_n(ras4), .o_cas_n(cas4), .o_we_n(we4), .o_ba(ba4),
        .o_addr(addr4), .o_odt(odt4), .o_init_done(done4), .o_state(st4));

    int n_cmp = 0;
    int n_bad = 0;
    int cnt1 = 0;
    int cnt2 = 0;

    // Edge counters: edge N is the Nth rising edge after release (or after the reinit edge).
    always @(posedge clk or posedge rst1) begin
        if (rst1)          cnt1 <= 0;
        else if (restart1) cnt1 <= 0;
        else               cnt1 <= cnt1 + 1;
    end
    always @(posedge clk or posedge rstb) begin
        if (rstb) cnt2 <= 0;
        else      cnt2 <= cnt2 + 1;
    end

    typedef struct {
        int         edge_n;
        logic [1:0] cs;
        logic [2:0] cmd;
        logic [2:0] ba;
        logic [13:0] addr;
    } cmd_t;
    cmd_t q1[$];
    cmd_t q2[$];

    typedef struct {
        int         id;
        int         edge_n;
        logic       rn;
        logic       cke;
        logic       done;
        logic [3:0] st;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic get_out(input int id, output logic rn, output logic cke, output logic done,
                           output logic [3:0] st, output logic [1:0] cs, output logic [2:0] cmd,
                           output logic [2:0] ba, output logic [13:0] addr);
        case (id)
            1: begin rn = rn1; cke = cke1; done = done1; st = st1; cs = {1'b1, cs1};
                     cmd = {ras1, cas1, we1}; ba = ba1; addr = addr1; end
            2: begin rn = rn2; cke = cke2; done = done2; st = st2; cs = cs2;
                     cmd = {ras2, cas2, we2}; ba = ba2; addr = addr2; end
            3: begin rn = rn3; cke = cke3; done = done3; st = st3; cs = {1'b1, cs3};
                     cmd = {ras3, cas3, we3}; ba = ba3; addr = addr3; end
            default: begin rn = rn4; cke = cke4; done = done4; st = st4; cs = {1'b1, cs4};
                     cmd = {ras4, cas4, we4}; ba = ba4; addr = addr4; end
        endcase
    endtask

    task automatic check_reset(input int id, input string tag);
        logic rn, cke, done; logic [3:0] st; logic [1:0] cs; logic [2:0] cmd, ba; logic [13:0] addr;
        get_out(id, rn, cke, done, st, cs, cmd, ba, addr);
        chk({tag, " reset_n"}, 32'(rn), 0);
        chk({tag, " cke"}, 32'(cke), 0);
        chk({tag, " init_done"}, 32'(done), 0);
        chk({tag, " state"}, 32'(st), 0);
        chk({tag, " cs_n"}, 32'(cs), 32'h3);
        chk({tag, " cmd"}, 32'(cmd), 32'h7);
        chk({tag, " ba"}, 32'(ba), 0);
        chk({tag, " addr"}, 32'(addr), 0);
    endtask

    // Expected MRS2,MRS3,MRS1,MRS0,ZQCL commands per rank, in issue order.
    task automatic push_cmds(input int which, input int nranks);
        logic [2:0]  bav[4];
        logic [13:0] mrv[4];
        int          w[4];
        int          e;
        cmd_t        c;
        bav = '{3'd2, 3'd3, 3'd1, 3'd0};
        mrv = '{14'h0018, 14'h0000, 14'h0004, 14'h0D70};
        w   = '{1, 1, 1, 3};
        e   = 66;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < nranks; r++) begin
                c = '{e, (r == 0) ? 2'b10 : 2'b01, 3'b000, bav[k], mrv[k]};
                if (which == 1) q1.push_back(c); else q2.push_back(c);
                e += w[k];
            end
        end
        for (int r = 0; r < nranks; r++) begin
            c = '{e, (r == 0) ? 2'b10 : 2'b01, 3'b110, 3'd0, 14'h0400};
            if (which == 1) q1.push_back(c); else q2.push_back(c);
            e += 128;
        end
    endtask

    task automatic mon(input int which, input int cnt);
        logic rn, cke, done; logic [3:0] st; logic [1:0] cs; logic [2:0] cmd, ba; logic [13:0] addr;
        cmd_t c;
        string t;
        get_out(which, rn, cke, done, st, cs, cmd, ba, addr);
        t = (which == 1) ? "dut1" : "dut2";
        if (cs == 2'b11) begin
            chk({t, " idle_nop"}, 32'(cmd), 32'h7);
        end else begin
            chk({t, " one_cs_low"}, 32'((cs == 2'b10) || (cs == 2'b01)), 1);
            if ((which == 1) ? (q1.size() == 0) : (q2.size() == 0)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s unexpected_cmd: got cmd=%b cs=%b at edge %0d, want none", t, cmd, cs, cnt);
            end else begin
                c = (which == 1) ? q1.pop_front() : q2.pop_front();
                chk({t, " cmd_edge"}, 32'(cnt), 32'(c.edge_n));
                chk({t, " cmd_cs"}, 32'(cs), 32'(c.cs));
                chk({t, " cmd_rcw"}, 32'(cmd), 32'(c.cmd));
                chk({t, " cmd_ba"}, 32'(ba), 32'(c.ba));
                chk({t, " cmd_addr"}, 32'(addr), 32'(c.addr));
            end
        end
    endtask

    always @(negedge clk) begin
        chk("dut1 odt", 32'(odt1), 0);
        chk("dut2 odt", 32'(odt2), 0);
        mon(1, cnt1);
        mon(2, cnt2);
    end

    task automatic wait_cnt(input int which, input int target);
        int guard = 0;
        while (((which == 1) ? cnt1 : cnt2) < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (((which == 1) ? cnt1 : cnt2) != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_edge: got counter %0d, want %0d", (which == 1) ? cnt1 : cnt2, target);
        end
    endtask

    task automatic addv(input int id, input int e, input logic rn, input logic cke,
                        input logic dn, input logic [3:0] st);
        vec_t v;
        v = '{id, e, rn, cke, dn, st};
        vecs.push_back(v);
    endtask

    task automatic chk_done(input string tag, input logic exp_done, input logic [3:0] exp_st);
        chk({tag, " init_done"}, 32'(done1), 32'(exp_done));
        chk({tag, " state"}, 32'(st1), 32'(exp_st));
    endtask

    initial begin
        // {dut, edge, reset_n, cke, init_done, state}, sorted by edge
        addv(1, 15, 0, 0, 0, 0);     addv(1, 16, 1, 0, 0, 1);     addv(2, 16, 1, 0, 0, 1);
        addv(1, 31, 1, 0, 0, 1);     addv(1, 32, 1, 1, 0, 2);     addv(1, 65, 1, 1, 0, 2);
        addv(1, 66, 1, 1, 0, 3);     addv(1, 68, 1, 1, 0, 5);     addv(1, 69, 1, 1, 0, 6);
        addv(1, 72, 1, 1, 0, 7);     addv(1, 199, 1, 1, 0, 7);    addv(4, 200, 0, 0, 0, 0);
        addv(1, 200, 1, 1, 1, 8);    addv(4, 201, 1, 0, 0, 1);    addv(4, 202, 1, 1, 0, 2);
        addv(4, 203, 1, 1, 0, 3);    addv(2, 205, 1, 1, 0, 7);    addv(2, 206, 1, 1, 0, 7);
        addv(2, 333, 1, 1, 0, 7);    addv(2, 334, 1, 1, 1, 8);    addv(3, 3999, 0, 0, 0, 0);
        addv(3, 4000, 1, 0, 0, 1);   addv(3, 13999, 1, 0, 0, 1);  addv(3, 14000, 1, 1, 0, 2);
        addv(3, 14003, 1, 1, 0, 2);  addv(3, 14004, 1, 1, 0, 3);

        repeat (3) @(negedge clk);
        for (int id = 1; id <= 4; id++) check_reset(id, $sformatf("dut%0d in_reset", id));

        push_cmds(1, 1);
        push_cmds(2, 2);
        rst1 = 1'b0;
        rstb = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            logic rn, cke, done; logic [3:0] st; logic [1:0] cs; logic [2:0] cmd, ba; logic [13:0] addr;
            string t;
            wait_cnt(2, vecs[i].edge_n);
            get_out(vecs[i].id, rn, cke, done, st, cs, cmd, ba, addr);
            t = $sformatf("vec%0d dut%0d edge%0d", i, vecs[i].id, vecs[i].edge_n);
            chk({t, " reset_n"}, 32'(rn), 32'(vecs[i].rn));
            chk({t, " cke"}, 32'(cke), 32'(vecs[i].cke));
            chk({t, " init_done"}, 32'(done), 32'(vecs[i].done));
            chk({t, " state"}, 32'(st), 32'(vecs[i].st));
        end

        // Reinit from DONE; a reinit pulse during MRS1 must be ignored.
        @(negedge clk);
        chk_done("before_reinit", 1'b1, 4'd8);
        push_cmds(1, 1);
        reinit1 = 1'b1; restart1 = 1'b1;
        @(negedge clk);
        reinit1 = 1'b0; restart1 = 1'b0;
        chk_done("reinit_next", 1'b0, 4'd0);
        chk("reinit_next reset_n", 32'(rn1), 0);
        chk("reinit_next cke", 32'(cke1), 0);
        wait_cnt(1, 68);
        chk("reinit_mrs1 state", 32'(st1), 5);
        reinit1 = 1'b1;
        @(negedge clk);
        reinit1 = 1'b0;
        chk_done("reinit_ignored", 1'b0, 4'd6);
        wait_cnt(1, 199);
        chk_done("reinit_e199", 1'b0, 4'd7);
        wait_cnt(1, 200);
        chk_done("reinit_e200", 1'b1, 4'd8);

        // Reset asserted in the cycle ZQCL is issued, then a full replay.
        @(negedge clk);
        push_cmds(1, 1);
        reinit1 = 1'b1; restart1 = 1'b1;
        @(negedge clk);
        reinit1 = 1'b0; restart1 = 1'b0;
        wait_cnt(1, 72);
        chk("abort zq_state", 32'(st1), 7);
        #2 rst1 = 1'b1;
        #1 check_reset(1, "abort async");
        chk("abort queue_drained", 32'(q1.size()), 0);
        repeat (2) @(negedge clk);
        check_reset(1, "abort held");
        push_cmds(1, 1);
        rst1 = 1'b0;
        wait_cnt(1, 199);
        chk_done("replay_e199", 1'b0, 4'd7);
        wait_cnt(1, 200);
        chk_done("replay_e200", 1'b1, 4'd8);

        @(negedge clk);
        chk("dut1 cmds_left", 32'(q1.size()), 0);
        chk("dut2 cmds_left", 32'(q2.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
